// File: rtl/pixel_pkg.sv
// Shared screen geometry and the packed pixel type used by the plot queue.
package pixel_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int PIXEL_W  = X_W + Y_W + COLOUR_W;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // True when the coordinate lies on the visible 160x120 screen.
    function automatic logic pixel_in_bounds(input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel storage array: one synchronous write port, one asynchronous read port.
// The array is never reset; validity is tracked by the pointers in the queue.
module pixel_fifo_mem
    import pixel_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data
);

    pixel_t mem [DEPTH];

    // Store the incoming pixel at the write pointer when the queue accepts it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_plot_queue.sv
// First-word fall-through pixel queue between the drawing logic and the VGA
// adapter. Rejected pixels (off-screen, or queue full) are tallied in a
// saturating drop counter.
module pixel_plot_queue
    import pixel_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    plot_in,
    input  logic [X_W-1:0]          x_in,
    input  logic [Y_W-1:0]          y_in,
    input  logic [COLOUR_W-1:0]     colour_in,
    input  logic                    flush,
    input  logic                    vga_ready,
    output logic                    vga_plot,
    output logic [X_W-1:0]          vga_x,
    output logic [Y_W-1:0]          vga_y,
    output logic [COLOUR_W-1:0]     vga_colour,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [DROP_W-1:0] drop_q;

    logic   in_bounds;
    logic   is_full;
    logic   is_empty;
    logic   do_pop;
    logic   do_push;
    logic   do_drop;
    pixel_t wr_pixel;
    pixel_t head;

    assign in_bounds = pixel_in_bounds(x_in, y_in);
    assign is_full   = (count_q == DEPTH_CNT);
    assign is_empty  = (count_q == '0);

    // Flush overrides everything: no pop, no push and no drop that cycle.
    // A push into a full queue is still taken when the head leaves together.
    assign do_pop  = !is_empty && vga_ready && !flush;
    assign do_push = plot_in && in_bounds && !flush && (!is_full || do_pop);
    assign do_drop = plot_in && !flush && !do_push;

    assign wr_pixel = '{x: x_in, y: y_in, colour: colour_in};

    pixel_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr),
        .wr_data (wr_pixel),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Count rejected pixels, sticking at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (do_drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign vga_plot   = !is_empty;
    assign vga_x      = head.x;
    assign vga_y      = head.y;
    assign vga_colour = head.colour;
    assign full       = is_full;
    assign empty      = is_empty;
    assign count      = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Randomised and directed bench for pixel_plot_queue with a queue-based
// reference model and a scoreboard monitor on the VGA side.
`timescale 1ns/1ps
module tb_pixel_plot_queue;

    localparam int DEPTH   = 8;
    localparam int DROP_W  = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                plot_in;
    logic [7:0]          x_in;
    logic [6:0]          y_in;
    logic [2:0]          colour_in;
    logic                flush;
    logic                vga_ready;
    logic                vga_plot;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [2:0]          vga_colour;
    logic                full;
    logic                empty;
    logic [$clog2(DEPTH):0] count;
    logic [DROP_W-1:0]   drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: expected pixels in order, occupancy and drop tally.
    logic [17:0] sb [$];
    int model_count = 0;
    int model_drop  = 0;

    pixel_plot_queue #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .plot_in    (plot_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .flush      (flush),
        .vga_ready  (vga_ready),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the status outputs against the model occupancy and drop tally.
    task automatic checkOutput();
        checkValue("count", int'(count), model_count);
        checkValue("full", int'(full), int'(model_count == DEPTH));
        checkValue("empty", int'(empty), int'(model_count == 0));
        checkValue("vga_plot", int'(vga_plot), int'(model_count != 0));
        checkValue("drop_count", int'(drop_count), model_drop);
    endtask

    // One clock cycle: check status at the falling edge, then drive inputs
    // and advance the model by the queue rules for the coming rising edge.
    task automatic applyStimulus(input bit p, input int x, input int y, input int c,
                                 input bit fl, input bit rdy);
        bit pop_m;
        bit inb;
        bit accept;
        logic [7:0] xv;
        logic [6:0] yv;
        logic [2:0] cv;
        @(negedge clk);
        checkOutput();
        xv = x[7:0];
        yv = y[6:0];
        cv = c[2:0];
        plot_in   = p;
        x_in      = xv;
        y_in      = yv;
        colour_in = cv;
        flush     = fl;
        vga_ready = rdy;
        pop_m  = (model_count > 0) && rdy && !fl;
        inb    = (x < 160) && (y < 120);
        accept = p && inb && !fl && ((model_count < DEPTH) || pop_m);
        if (fl) begin
            model_count = 0;
            sb.delete();
        end else begin
            if (accept) sb.push_back({xv, yv, cv});
            model_count = model_count + int'(accept) - int'(pop_m);
            if (p && !accept && model_drop < DROP_MAX) model_drop++;
        end
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, rdy);
    endtask

    // Monitor: just before each rising edge, the presented head must match the
    // oldest expected pixel; a transfer retires it from the scoreboard.
    initial begin
        logic [17:0] exp_px;
        forever begin
            @(negedge clk);
            #4;
            if (reset_n && vga_plot && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pixel: got vga_plot=1, expected no pixel at %0t", $time);
                end else begin
                    exp_px = sb[0];
                    checkValue("vga_x", int'(vga_x), int'(exp_px[17:10]));
                    checkValue("vga_y", int'(vga_y), int'(exp_px[9:3]));
                    checkValue("vga_colour", int'(vga_colour), int'(exp_px[2:0]));
                    if (vga_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        plot_in   = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        flush     = 1'b0;
        vga_ready = 1'b0;
        #3;
        checkOutput();
        #9;
        reset_n = 1'b1;

        $display("[TB] single pixel through empty queue");
        applyStimulus(1'b1, 10, 20, 3'b100, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] overfill with VGA stalled");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, i * 3, i * 2, i % 8, 1'b0, 1'b0);

        $display("[TB] push while full with simultaneous pop");
        applyStimulus(1'b1, 150, 100, 5, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("[TB] out-of-bounds pixels");
        applyStimulus(1'b1, 160, 5, 1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3, 120, 2, 1'b0, 1'b1);
        idle(1'b0);

        $display("[TB] flush with five queued");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 40 + i, 50 + i, i, 1'b0, 1'b0);
        applyStimulus(1'b1, 7, 7, 7, 1'b1, 1'b1);
        idle(1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 60 + i, 70 + i, i, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput();
        plot_in   = 1'b0;
        vga_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        sb.delete();
        model_count = 0;
        model_drop  = 0;
        #1;
        checkOutput();
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 90, 45, 6, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 175)),
                          int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                          $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < DROP_MAX + 10; i++) applyStimulus(1'b1, 200, 10, 1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkValue("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
